// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch-PC generator with branch/return redirects,
// a stall hold, a saturating redirect counter and a circular return-address
// stack that flags return targets disagreeing with the predicted entry.
module pc_sequencer #(
    parameter int                 ADDR_W    = 64,
    parameter int                 ISZ_LOG2  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 RAS_DEPTH = 4,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic              br_link,
    input  logic              br_ret,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [25:0]       br_addr26,
    input  logic [18:0]       cond_addr19,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_mismatch,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] INC  = {{(ADDR_W-1){1'b0}}, 1'b1} << ISZ_LOG2;
    localparam logic [PTR_W:0]    FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic signed [25:0]       a26_s;
    logic signed [18:0]       a19_s;
    logic signed [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0]        br_target;
    logic [ADDR_W-1:0]        push_addr;
    logic [PTR_W-1:0]         top_idx;
    logic [ADDR_W-1:0]        top_val;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     redir;

    // Branch target arithmetic: sign-extended instruction-count offset scaled to bytes.
    always_comb begin
        a26_s     = br_addr26;
        a19_s     = cond_addr19;
        off_s     = uncond_br ? ADDR_W'(a26_s) : ADDR_W'(a19_s);
        off_s     = off_s <<< ISZ_LOG2;
        br_target = br_pc + $unsigned(off_s);
        push_addr = br_pc + INC;
    end

    // Stack bookkeeping: the write pointer names the next free slot, so the
    // top sits one below it; when full the next push lands on the oldest entry.
    always_comb begin
        empty    = (occ_q == '0);
        top_idx  = wr_ptr_q - PTR_W'(1);
        top_val  = ras_mem[top_idx];
        redir    = br_ret | br_taken;
        push     = br_taken & br_link & ~br_ret;
        pop      = br_ret & ~empty;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        mis_d    = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (occ_q != FULL) begin
                occ_d = occ_q + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            wr_ptr_d = top_idx;
            occ_d    = occ_q - (PTR_W+1)'(1);
            mis_d    = (top_val != reg_target);
        end
    end

    // Next-PC selection (return beats branch beats stall) and saturating redirect count.
    always_comb begin
        if (br_ret) begin
            pc_d = reg_target;
        end else if (br_taken) begin
            pc_d = br_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + INC;
        end
        cnt_d = cnt_q;
        if (redir && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control and PC state; reset wins over any same-edge redirect or push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stack storage; contents are only visible through a non-zero occupancy,
    // so entries need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_ptr_q] <= push_addr;
        end
    end

    assign pc           = pc_q;
    assign ras_empty    = empty;
    assign ras_top      = empty ? '0 : top_val;
    assign ras_mismatch = mis_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the PC and return stack.
module tb_pc_sequencer;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          stall, br_taken, uncond_br, br_link, br_ret;
  logic [AW-1:0] br_pc, reg_target;
  logic [25:0]   br_addr26;
  logic [18:0]   cond_addr19;
  logic [AW-1:0] pc, ras_top;
  logic          ras_empty, ras_mismatch;
  logic [CW-1:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ras[$];
  int            m_cnt;
  logic          m_mis;

  pc_sequencer #(
    .ADDR_W(AW), .ISZ_LOG2(2), .RESET_PC('0), .RAS_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .uncond_br(uncond_br), .br_link(br_link), .br_ret(br_ret),
    .br_pc(br_pc), .br_addr26(br_addr26), .cond_addr19(cond_addr19),
    .reg_target(reg_target), .pc(pc), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_mismatch(ras_mismatch),
    .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] top;
    top = (m_ras.size() > 0) ? m_ras[$] : '0;
    check({tag, ".pc"},    pc, m_pc);
    check({tag, ".top"},   ras_top, top);
    check({tag, ".empty"}, AW'(ras_empty), AW'(m_ras.size() == 0));
    check({tag, ".mis"},   AW'(ras_mismatch), AW'(m_mis));
    check({tag, ".cnt"},   AW'(redirect_cnt), AW'(m_cnt));
  endtask

  task automatic drive(input logic ret, input logic taken, input logic unc, input logic link,
                       input logic stl, input logic [AW-1:0] bpc, input logic [25:0] a26,
                       input logic [18:0] c19, input logic [AW-1:0] rt);
    br_ret = ret; br_taken = taken; uncond_br = unc; br_link = link; stall = stl;
    br_pc = bpc; br_addr26 = a26; cond_addr19 = c19; reg_target = rt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic cycle(input string tag);
    logic signed [AW-1:0] so;
    logic [AW-1:0]        nxt;
    logic [AW-1:0]        popped;
    if (uncond_br) so = $signed(br_addr26);
    else           so = $signed(cond_addr19);
    if (br_ret)        nxt = reg_target;
    else if (br_taken) nxt = br_pc + AW'(so * 4);
    else if (stall)    nxt = m_pc;
    else               nxt = m_pc + 4;
    m_mis = 1'b0;
    if (br_ret) begin
      if (m_ras.size() > 0) begin
        popped = m_ras.pop_back();
        m_mis = (popped != reg_target);
      end
    end else if (br_taken && br_link) begin
      m_ras.push_back(br_pc + 4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    if ((br_ret || br_taken) && m_cnt < CMAX) m_cnt++;
    m_pc = nxt;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_ras.delete();
    m_cnt = 0;
    m_mis = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // T1: reset state and sequential fetch
    check_all("t1_reset");
    reset = 1'b0;
    repeat (3) cycle("t1_seq");
    check("t1_pc12", pc, 64'hC);

    // T2: conditional branch backwards by two instructions
    drive(0, 1, 0, 0, 0, 64'h100, '0, 19'h7FFFE, '0);
    cycle("t2_br");
    check("t2_pcF8", pc, 64'hF8);
    check("t2_cnt1", AW'(redirect_cnt), 64'd1);
    idle();
    cycle("t2_seq");
    check("t2_pcFC", pc, 64'hFC);

    // T3: stall hold, then a branch taken while stalled
    drive(0, 1, 0, 0, 0, 64'h20, '0, '0, '0);
    cycle("t3_to20");
    drive(0, 0, 0, 0, 1, '0, '0, '0, '0);
    cycle("t3_hold1");
    cycle("t3_hold2");
    check("t3_pc20", pc, 64'h20);
    drive(0, 1, 1, 0, 1, 64'h20, 26'd3, '0, '0);
    cycle("t3_br");
    check("t3_pc2C", pc, 64'h2C);

    // T4: branch-and-link then matching return
    drive(0, 1, 1, 1, 0, 64'h40, 26'h10, '0, '0);
    cycle("t4_bl");
    check("t4_pc80", pc, 64'h80);
    check("t4_top44", ras_top, 64'h44);
    drive(1, 0, 0, 0, 0, '0, '0, '0, 64'h44);
    cycle("t4_ret");
    check("t4_pc44", pc, 64'h44);
    check("t4_empty", AW'(ras_empty), 64'd1);
    check("t4_nomis", AW'(ras_mismatch), 64'd0);

    // Return with an empty stack: redirect only, no mismatch
    drive(1, 0, 0, 0, 0, '0, '0, '0, 64'h300);
    cycle("emp_ret");
    check("emp_nomis", AW'(ras_mismatch), 64'd0);

    // T5: overflow the stack, oldest entry lost
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 1, 1, 1, 0, AW'(i * 16), 26'h10, '0, '0);
      cycle("t5_bl");
    end
    check("t5_top", ras_top, AW'(DEPTH * 16 + 4));
    drive(1, 0, 0, 0, 0, '0, '0, '0, 64'h4);
    cycle("t5_ret");
    check("t5_mis", AW'(ras_mismatch), 64'd1);

    // Return and branch-and-link together: return wins, nothing pushed
    drive(1, 1, 1, 1, 1, 64'h1000, 26'h5, '0, 64'h700);
    cycle("both");
    check("both_pc", pc, 64'h700);

    // T6: address wrap-around
    drive(1, 0, 0, 0, 0, '0, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle("t6_top");
    idle();
    cycle("t6_wrap");
    check("t6_pc0", pc, 64'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] rt;
      logic [AW-1:0] bp;
      bp = {$urandom, $urandom} & ~64'h3;
      if (n % 50 < 3) bp = 64'hFFFF_FFFF_FFFF_FFF0;
      rt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 1) == 1 && m_ras.size() > 0) rt = m_ras[$];
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
            1'($urandom), $urandom_range(0, 2) == 0, bp, 26'($urandom), 19'($urandom), rt);
      cycle("rnd");
    end

    // T6b: asynchronous reset in the middle of a return cycle
    drive(0, 1, 1, 1, 0, 64'h200, 26'h4, '0, '0);
    cycle("t6b_bl");
    drive(1, 0, 0, 0, 0, '0, '0, '0, 64'h500);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6b_async");
    @(posedge clk);
    #1;
    check_all("t6b_held");
    reset = 1'b0;
    idle();
    cycle("t6b_after");
    check("t6b_pc4", pc, 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
